// File: rtl/svreal_fp_pkg.sv
// rtl/svreal_fp_pkg.sv - shared FP32 constants, FSM state type and shift-count type for svreal_to_fp32_mod
package svreal_fp_pkg;

  localparam int FP32_BIAS    = 127;
  localparam int FP32_FRAC_W  = 23;
  localparam int FP32_EXP_MAX = 255;

  // Widest svreal mantissa the converter accepts; sizes the shift tally.
  localparam int SVREAL_MAX_W = 64;
  localparam int SHCNT_W      = $clog2(SVREAL_MAX_W + 1);

  typedef logic [SHCNT_W-1:0] svreal_shcnt_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_NORM,
    ST_PACK,
    ST_DONE
  } svreal_fp32_state_t;

endpackage

// File: rtl/svreal.sv
// rtl/svreal.sv - svreal number bundle: signed mantissa plus runtime exponent
interface svreal #(
  parameter int W = 16
) ();

  logic [W-1:0] value;
  logic [31:0]  exponent;

  modport in  (input  value, input  exponent);
  modport out (output value, output exponent);

endinterface

// File: rtl/svreal_fp32_pack_mod.sv
// rtl/svreal_fp32_pack_mod.sv - combinational FP32 packer; SVREAL_TO_FP32_RNE_EN selects round-nearest-even over truncation
module svreal_fp32_pack_mod
  import svreal_fp_pkg::*;
#(
  parameter int W = 16
) (
  input  logic                s,
  input  logic [W-1:0]        m,
  input  logic signed [39:0]  e,
  output logic [31:0]         out_bits,
  output logic                ovf,
  output logic                unf
);

  localparam logic signed [39:0] BIAS_C    = 40'(FP32_BIAS);
  localparam logic signed [39:0] EXP_MAX_C = 40'(FP32_EXP_MAX);

  logic [22:0]        frac_raw;
  logic               carry;
  logic signed [39:0] b;

  generate
    if (W - 1 <= FP32_FRAC_W) begin : g_pad
      // Narrow mantissas fit entirely; left-align and pad with zeros.
      assign frac_raw = 23'(m[W-2:0]) << (FP32_FRAC_W - (W - 1));
      assign carry    = 1'b0;
    end else begin : g_reduce
      logic [22:0] top;
      assign top = m[W-2 -: 23];
`ifdef SVREAL_TO_FP32_RNE_EN
      logic [W-25:0] low;
      logic [W-25:0] low_sh;
      logic          guard;
      logic          rest;
      logic          up;
      logic [23:0]   sum;
      assign low    = m[W-25:0];
      assign low_sh = low << 1;
      assign guard  = low[W-25];
      assign rest   = |low_sh;
      // Round up above half, or at exactly half when the kept LSB is odd.
      assign up       = guard & (rest | top[0]);
      assign sum      = {1'b0, top} + {23'b0, up};
      assign frac_raw = sum[22:0];
      assign carry    = sum[23];
`else
      logic unused_low;
      assign unused_low = ^m[W-25:0];
      assign frac_raw   = top;
      assign carry      = 1'b0;
`endif
    end
  endgenerate

  assign b = e + BIAS_C + $signed({39'b0, carry});

  // Select zero, saturated infinity, flushed zero or the normal encoding.
  always_comb begin
    out_bits = 32'h0;
    ovf      = 1'b0;
    unf      = 1'b0;
    if (!m[W-1]) begin
      out_bits = 32'h0;
    end else if (b >= EXP_MAX_C) begin
      out_bits = {s, 8'hFF, 23'h0};
      ovf      = 1'b1;
    end else if (b <= 40'sd0) begin
      out_bits = {s, 31'h0};
      unf      = 1'b1;
    end else begin
      out_bits = {s, b[7:0], frac_raw};
    end
  end

endmodule

// File: rtl/svreal_to_fp32_mod.sv
// rtl/svreal_to_fp32_mod.sv - multi-cycle svreal to IEEE-754 binary32 converter; rounding mode set by SVREAL_TO_FP32_RNE_EN
module svreal_to_fp32_mod
  import svreal_fp_pkg::*;
#(
  parameter int STEP = 4
) (
  input  logic        clk,
  input  logic        rst,
  svreal.in           a,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_bits,
  output logic        ovf,
  output logic        unf
);

  localparam int W = $bits(a.value);
  localparam svreal_shcnt_t      STEP_C = svreal_shcnt_t'(STEP);
  localparam logic signed [39:0] WM1_C  = 40'(W - 1);

  generate
    if (W < 2 || W > SVREAL_MAX_W || STEP < 1 || STEP > W) begin : g_bad_cfg
      $fatal(1, "svreal_to_fp32_mod: unsupported W or STEP");
    end
  endgenerate

  svreal_fp32_state_t state_q, state_d;

  logic [W-1:0]       m_q;
  logic               s_q;
  logic signed [39:0] x_q;
  svreal_shcnt_t      lz_q;

  logic [W-1:0]       mag_c;
  svreal_shcnt_t      lz_c;
  svreal_shcnt_t      k_c;
  logic [W-1:0]       m_sh;
  logic signed [39:0] e_c;

  logic [31:0]        pk_bits;
  logic               pk_ovf;
  logic               pk_unf;

  // Two's-complement magnitude; the most negative value maps to 2^(W-1).
  assign mag_c = a.value[W-1] ? (~a.value + {{(W-1){1'b0}}, 1'b1}) : a.value;

  // Leading-zero count of the working mantissa and the bounded shift for this cycle.
  always_comb begin
    lz_c = svreal_shcnt_t'(W);
    for (int i = 0; i < W; i++) begin
      if (m_q[i]) lz_c = svreal_shcnt_t'(W - 1 - i);
    end
    k_c  = (lz_c < STEP_C) ? lz_c : STEP_C;
    m_sh = m_q << k_c;
  end

  assign e_c = x_q + WM1_C - $signed({{(40 - SHCNT_W){1'b0}}, lz_q});

  svreal_fp32_pack_mod #(.W(W)) u_pack (
    .s        (s_q),
    .m        (m_q),
    .e        (e_c),
    .out_bits (pk_bits),
    .ovf      (pk_ovf),
    .unf      (pk_unf)
  );

  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign out_valid = (state_q == ST_DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: skip NORM for zero or already-normalized inputs.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid) state_d = ((mag_c == '0) || mag_c[W-1]) ? ST_PACK : ST_NORM;
      ST_NORM: if (m_sh[W-1]) state_d = ST_PACK;
      ST_PACK: state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Capture operands, normalize step by step, then register the packed result.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_q      <= '0;
      s_q      <= 1'b0;
      x_q      <= '0;
      lz_q     <= '0;
      out_bits <= 32'h0;
      ovf      <= 1'b0;
      unf      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            s_q  <= a.value[W-1];
            m_q  <= mag_c;
            x_q  <= {{8{a.exponent[31]}}, a.exponent};
            lz_q <= '0;
          end
        end
        ST_NORM: begin
          m_q  <= m_sh;
          lz_q <= lz_q + k_c;
        end
        ST_PACK: begin
          out_bits <= pk_bits;
          ovf      <= pk_ovf;
          unf      <= pk_unf;
        end
        default: ;
      endcase
    end
  end

endmodule
